// File: rtl/cordic_uart_bridge.sv
// Framing bridge: UART RX bytes -> CORDIC operand issue, CORDIC results -> FIFO -> UART TX frames.
// RX side parses A0/A1 command frames with timeout resync and credit gating; TX side serialises results.
module cordic_uart_bridge #(
   parameter int unsigned DATA_WIDTH   = 18,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned TIMEOUT_CLKS = 17400,
   parameter logic [DATA_WIDTH-1:0] X_INIT = DATA_WIDTH'(18'h026de)
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_rx_valid,
   input  logic [7:0]                    i_rx_byte,
   output logic [DATA_WIDTH-1:0]         o_cordic_x,
   output logic [DATA_WIDTH-1:0]         o_cordic_y,
   output logic [DATA_WIDTH-1:0]         o_cordic_alpha,
   output logic                          o_cordic_valid,
   input  logic [DATA_WIDTH-1:0]         i_cordic_cos,
   input  logic [DATA_WIDTH-1:0]         i_cordic_sin,
   input  logic                          i_cordic_valid,
   output logic [7:0]                    o_tx_byte,
   output logic                          o_tx_dv,
   input  logic                          i_tx_done,
   output logic                          o_busy,
   output logic                          o_frame_err,
   output logic                          o_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int unsigned NB     = (DATA_WIDTH + 7) / 8;
   localparam int unsigned NB_OUT = (2 * DATA_WIDTH + 7) / 8;
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned LW     = AW + 1;
   localparam int unsigned TW     = $clog2(TIMEOUT_CLKS + 1);
   localparam int unsigned RIW    = $clog2(NB + 1);
   localparam int unsigned TIW    = $clog2(NB_OUT + 1);
   localparam int unsigned RW     = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {R_IDLE, R_X, R_A, R_ISSUE} rx_state_t;
   typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;

   rx_state_t               rx_state, rx_next;
   tx_state_t               tx_state, tx_next;

   logic                    pend_v;
   logic [7:0]              pend_b;
   logic                    byte_v;
   logic [7:0]              in_b;
   logic [RIW-1:0]          rx_idx;
   logic [NB*8-1:0]         asm_r, asm_nxt;
   logic [DATA_WIDTH-1:0]   x_reg, a_reg;
   logic [TW-1:0]           to_cnt;
   logic [LW-1:0]           outstanding;
   logic                    last_b, timeout, credit_ok;
   logic                    frame_err_c, issue_c, drop_c, x_init_c, ld_x_c, ld_a_c, shift_c;

   logic [RW-1:0]           mem [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic                    fifo_full;

   logic [NB_OUT*8-1:0]     tx_sr;
   logic [TIW-1:0]          tx_idx;
   logic                    pop_c, ld_sr_c, shift_sr_c, dv_c;
   logic [7:0]              byte_nxt;

   // A byte caught during R_ISSUE is parked and consumed as the next header.
   assign byte_v    = pend_v | i_rx_valid;
   assign in_b      = pend_v ? pend_b : i_rx_byte;
   assign asm_nxt   = (NB*8)'({in_b, asm_r} >> 8);
   assign last_b    = (rx_idx == RIW'(NB - 1));
   assign timeout   = (to_cnt == TW'(TIMEOUT_CLKS));
   assign credit_ok = (({1'b0, outstanding} + {1'b0, o_fifo_level}) < (LW+1)'(FIFO_DEPTH));
   assign fifo_full = (o_fifo_level == LW'(FIFO_DEPTH));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rx_state <= R_IDLE;
         tx_state <= T_IDLE;
      end else begin
         rx_state <= rx_next;
         tx_state <= tx_next;
      end
   end

   // RX frame parser
   always_comb begin
      rx_next     = rx_state;
      frame_err_c = 1'b0;
      issue_c     = 1'b0;
      drop_c      = 1'b0;
      x_init_c    = 1'b0;
      ld_x_c      = 1'b0;
      ld_a_c      = 1'b0;
      shift_c     = 1'b0;
      case (rx_state)
         R_IDLE: begin
            if (byte_v) begin
               if (in_b == 8'hA0) begin
                  rx_next  = R_A;
                  x_init_c = 1'b1;
               end else if (in_b == 8'hA1) begin
                  rx_next = R_X;
               end else begin
                  frame_err_c = 1'b1;
               end
            end
         end
         R_X: begin
            if (byte_v) begin
               shift_c = 1'b1;
               if (last_b) begin
                  ld_x_c  = 1'b1;
                  rx_next = R_A;
               end
            end else if (timeout) begin
               rx_next     = R_IDLE;
               frame_err_c = 1'b1;
            end
         end
         R_A: begin
            if (byte_v) begin
               shift_c = 1'b1;
               if (last_b) begin
                  ld_a_c  = 1'b1;
                  rx_next = R_ISSUE;
               end
            end else if (timeout) begin
               rx_next     = R_IDLE;
               frame_err_c = 1'b1;
            end
         end
         R_ISSUE: begin
            rx_next = R_IDLE;
            if (credit_ok) issue_c = 1'b1;
            else           drop_c  = 1'b1;
         end
         default: rx_next = R_IDLE;
      endcase
   end

   // TX serialiser: header, then result bytes LSB-first, each paced by i_tx_done
   always_comb begin
      tx_next    = tx_state;
      pop_c      = 1'b0;
      ld_sr_c    = 1'b0;
      shift_sr_c = 1'b0;
      dv_c       = 1'b0;
      byte_nxt   = o_tx_byte;
      case (tx_state)
         T_IDLE: begin
            if (o_fifo_level != '0) begin
               pop_c    = 1'b1;
               ld_sr_c  = 1'b1;
               dv_c     = 1'b1;
               byte_nxt = 8'h55;
               tx_next  = T_SEND;
            end
         end
         T_SEND: tx_next = T_WAIT;
         T_WAIT: begin
            if (i_tx_done) begin
               if (tx_idx == TIW'(NB_OUT)) begin
                  tx_next = T_IDLE;
               end else begin
                  tx_next    = T_SEND;
                  dv_c       = 1'b1;
                  byte_nxt   = tx_sr[7:0];
                  shift_sr_c = 1'b1;
               end
            end
         end
         default: tx_next = T_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend_v         <= 1'b0;
         pend_b         <= 8'h00;
         rx_idx         <= '0;
         asm_r          <= '0;
         x_reg          <= '0;
         a_reg          <= '0;
         to_cnt         <= '0;
         outstanding    <= '0;
         o_cordic_x     <= '0;
         o_cordic_y     <= '0;
         o_cordic_alpha <= '0;
         o_cordic_valid <= 1'b0;
         o_frame_err    <= 1'b0;
         o_overflow     <= 1'b0;
         o_busy         <= 1'b0;
      end else begin
         if (rx_state == R_ISSUE) begin
            if (i_rx_valid) begin
               pend_v <= 1'b1;
               pend_b <= i_rx_byte;
            end
         end else begin
            pend_v <= pend_v & i_rx_valid;
            if (i_rx_valid) pend_b <= i_rx_byte;
         end

         if (rx_state == R_IDLE || byte_v) to_cnt <= '0;
         else if (!timeout)                to_cnt <= to_cnt + TW'(1);

         if (rx_state == R_IDLE) rx_idx <= '0;
         else if (shift_c)       rx_idx <= last_b ? '0 : rx_idx + RIW'(1);

         if (shift_c)  asm_r <= asm_nxt;
         if (x_init_c) x_reg <= X_INIT;
         if (ld_x_c)   x_reg <= asm_nxt[DATA_WIDTH-1:0];
         if (ld_a_c)   a_reg <= asm_nxt[DATA_WIDTH-1:0];

         o_cordic_valid <= issue_c;
         o_cordic_y     <= '0;
         if (issue_c) begin
            o_cordic_x     <= x_reg;
            o_cordic_alpha <= a_reg;
         end

         case ({issue_c, i_cordic_valid})
            2'b10:   outstanding <= outstanding + LW'(1);
            2'b01:   outstanding <= outstanding - LW'(1);
            default: outstanding <= outstanding;
         endcase

         o_frame_err <= frame_err_c;
         if (drop_c) o_overflow <= 1'b1;
         o_busy <= (rx_next != R_IDLE) | (tx_next != T_IDLE);
      end
   end

   // Result FIFO and TX datapath
   always_ff @(posedge i_clk) begin
      if (i_cordic_valid) mem[wr_ptr] <= {i_cordic_cos, i_cordic_sin};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         o_fifo_level <= '0;
         tx_sr        <= '0;
         tx_idx       <= '0;
         o_tx_dv      <= 1'b0;
         o_tx_byte    <= 8'h00;
      end else begin
         if (i_cordic_valid) wr_ptr <= wr_ptr + AW'(1);
         if (pop_c)          rd_ptr <= rd_ptr + AW'(1);
         case ({i_cordic_valid, pop_c})
            2'b10:   o_fifo_level <= o_fifo_level + LW'(1);
            2'b01:   o_fifo_level <= o_fifo_level - LW'(1);
            default: o_fifo_level <= o_fifo_level;
         endcase

         if (ld_sr_c) begin
            tx_sr  <= (NB_OUT*8)'(mem[rd_ptr]);
            tx_idx <= '0;
         end else if (shift_sr_c) begin
            tx_sr  <= tx_sr >> 8;
            tx_idx <= tx_idx + TIW'(1);
         end

         o_tx_dv   <= dv_c;
         o_tx_byte <= byte_nxt;
      end
   end

   a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_cordic_valid && fifo_full));

endmodule

// File: tb/tb_cordic_uart_bridge.sv
// Directed bench for cordic_uart_bridge: delayed-echo CORDIC model (cos=x, sin=alpha, 20 clocks)
// and an auto-responding transmitter that collects output bytes.
module tb_cordic_uart_bridge;

   localparam int unsigned DW  = 18;
   localparam int unsigned TO  = 40;
   localparam int unsigned LAT = 20;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b1;
   logic            i_rx_valid = 1'b0;
   logic [7:0]      i_rx_byte = 8'h00;
   logic [DW-1:0]   o_cordic_x, o_cordic_y, o_cordic_alpha;
   logic            o_cordic_valid;
   logic [DW-1:0]   i_cordic_cos, i_cordic_sin;
   logic            i_cordic_valid;
   logic [7:0]      o_tx_byte;
   logic            o_tx_dv;
   logic            i_tx_done = 1'b0;
   logic            o_busy, o_frame_err, o_overflow;
   logic [2:0]      o_fifo_level;

   cordic_uart_bridge #(.DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT_CLKS(TO)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte),
      .o_cordic_x(o_cordic_x), .o_cordic_y(o_cordic_y), .o_cordic_alpha(o_cordic_alpha),
      .o_cordic_valid(o_cordic_valid),
      .i_cordic_cos(i_cordic_cos), .i_cordic_sin(i_cordic_sin), .i_cordic_valid(i_cordic_valid),
      .o_tx_byte(o_tx_byte), .o_tx_dv(o_tx_dv), .i_tx_done(i_tx_done),
      .o_busy(o_busy), .o_frame_err(o_frame_err), .o_overflow(o_overflow),
      .o_fifo_level(o_fifo_level)
   );

   always #5 i_clk = ~i_clk;

   // CORDIC stand-in: echoes x as cos and alpha as sin after LAT clocks
   logic [LAT-1:0] mv;
   logic [DW-1:0]  mx [LAT];
   logic [DW-1:0]  ma [LAT];
   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) mv <= '0;
      else begin
         mv    <= {mv[LAT-2:0], o_cordic_valid};
         mx[0] <= o_cordic_x;
         ma[0] <= o_cordic_alpha;
         for (int i = 1; i < LAT; i++) begin
            mx[i] <= mx[i-1];
            ma[i] <= ma[i-1];
         end
      end
   end
   assign i_cordic_valid = mv[LAT-1];
   assign i_cordic_cos   = mx[LAT-1];
   assign i_cordic_sin   = ma[LAT-1];

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Output monitor and transmitter responder
   int          cyc = 0, done_cyc = -10, done_cnt = 0, mon_idx = 0;
   int          iss_cnt = 0, fe_cnt = 0, dv_viol = 0, lat_err = 0;
   bit          tx_auto = 1'b1, pend = 1'b0;
   logic [DW-1:0] iss_x, iss_y, iss_a;
   logic [7:0]  txq [$];

   always @(negedge i_clk) begin
      cyc++;
      i_tx_done = 1'b0;
      if (i_rst) begin
         pend    = 1'b0;
         mon_idx = 0;
      end else begin
         if (o_cordic_valid) begin
            iss_cnt++;
            iss_x = o_cordic_x;
            iss_y = o_cordic_y;
            iss_a = o_cordic_alpha;
         end
         if (o_frame_err) fe_cnt++;
         if (o_tx_dv) begin
            txq.push_back(o_tx_byte);
            if (pend) dv_viol++;
            if (mon_idx != 0 && cyc != done_cyc + 1) lat_err++;
            mon_idx  = (mon_idx == 5) ? 0 : mon_idx + 1;
            pend     = 1'b1;
            done_cnt = 3;
         end else if (pend && tx_auto) begin
            done_cnt--;
            if (done_cnt == 0) begin
               i_tx_done = 1'b1;
               pend      = 1'b0;
               done_cyc  = cyc;
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge i_clk);
      i_rx_valid = 1'b1;
      i_rx_byte  = b;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         i_rx_valid = 1'b0;
      end
   endtask

   task automatic send_a0(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(8'hA0); send_byte(b0); send_byte(b1); send_byte(b2);
      idle(1);
   endtask

   task automatic wait_issue(input int n, input int budget);
      int t = 0;
      while (iss_cnt < n && t < budget) begin
         @(negedge i_clk);
         t++;
      end
      check("issue_count", 64'(iss_cnt), 64'(n));
   endtask

   // Expects 0x55 then 5 bytes of the hand-packed {pad,cos,sin} value, LSB first
   task automatic expect_frame(input string tag, input logic [39:0] packed_v);
      int t = 0;
      logic [39:0] v;
      logic [15:0] got;
      while (txq.size() < 6 && t < 400) begin
         @(negedge i_clk);
         t++;
      end
      check({tag, "_len"}, 64'(txq.size()), 64'd6);
      v = packed_v;
      for (int i = 0; i < 6; i++) begin
         got = (txq.size() > 0) ? {8'h00, txq.pop_front()} : 16'h0100;
         if (i == 0) check({tag, "_hdr"}, 64'(got), 64'h55);
         else begin
            check({tag, "_byte"}, 64'(got), 64'(v[7:0]));
            v = v >> 8;
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_valid"}, 64'(o_cordic_valid), 64'd0);
      check({tag, "_x"},     64'(o_cordic_x),     64'd0);
      check({tag, "_alpha"}, 64'(o_cordic_alpha), 64'd0);
      check({tag, "_dv"},    64'(o_tx_dv),        64'd0);
      check({tag, "_byte"},  64'(o_tx_byte),      64'd0);
      check({tag, "_busy"},  64'(o_busy),         64'd0);
      check({tag, "_ferr"},  64'(o_frame_err),    64'd0);
      check({tag, "_ovf"},   64'(o_overflow),     64'd0);
      check({tag, "_level"}, 64'(o_fifo_level),   64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   int base_iss, base_fe;

   initial begin
      idle(3);
      check_reset_outputs("rst");
      @(negedge i_clk);
      i_rst = 1'b0;
      idle(3);

      // A0 default-x frame, alpha 0
      send_a0(8'h00, 8'h00, 8'h00);
      wait_issue(1, 50);
      check("t1_x", 64'(iss_x), 64'h026de);
      check("t1_y", 64'(iss_y), 64'h0);
      check("t1_alpha", 64'(iss_a), 64'h0);
      expect_frame("t1", 40'h00_9B78_0000);

      // A1 explicit-x frame
      send_byte(8'hA1); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      send_byte(8'h00); send_byte(8'h80); send_byte(8'h00); idle(1);
      wait_issue(2, 50);
      check("t2_x", 64'(iss_x), 64'h01000);
      check("t2_alpha", 64'(iss_a), 64'h08000);
      expect_frame("t2", 40'h00_4000_8000);

      // Pad bits above bit 17 are discarded
      send_a0(8'h00, 8'h80, 8'hFF);
      wait_issue(3, 50);
      check("t2b_x", 64'(iss_x), 64'h026de);
      check("t2b_alpha", 64'(iss_a), 64'h38000);
      expect_frame("t2b", 40'h00_9B7B_8000);

      // Partial frame then silence: one frame error, no issue
      base_fe = fe_cnt;
      send_byte(8'hA0); send_byte(8'h12);
      idle(TO + 20);
      check("t3_ferr", 64'(fe_cnt), 64'(base_fe + 1));
      check("t3_noissue", 64'(iss_cnt), 64'd3);
      check("t3_busy", 64'(o_busy), 64'd0);
      send_a0(8'h01, 8'h00, 8'h00);
      wait_issue(4, 50);
      check("t3_alpha", 64'(iss_a), 64'h00001);
      expect_frame("t3", 40'h00_9B78_0001);

      // Bad header, then a header landing in the R_ISSUE cycle
      base_fe = fe_cnt;
      send_byte(8'h33); idle(3);
      check("t4_ferr", 64'(fe_cnt), 64'(base_fe + 1));
      check("t4_noissue", 64'(iss_cnt), 64'd4);
      send_byte(8'hA0); send_byte(8'h03); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'hA0); idle(2);
      send_byte(8'h04); send_byte(8'h00); send_byte(8'h00); idle(1);
      wait_issue(6, 50);
      check("t4_alpha", 64'(iss_a), 64'h00004);
      check("t4_noerr", 64'(fe_cnt), 64'(base_fe + 1));
      expect_frame("t4a", 40'h00_9B78_0003);
      expect_frame("t4b", 40'h00_9B78_0004);
      idle(10);

      // Credit exhaustion with the transmitter stalled
      tx_auto  = 1'b0;
      base_iss = iss_cnt;
      for (int k = 0; k < 5; k++) send_a0(8'(8'h10 + k), 8'h00, 8'h00);
      idle(60);
      check("t5_issues", 64'(iss_cnt - base_iss), 64'd4);
      check("t5_ovf", 64'(o_overflow), 64'd1);
      check("t5_level", 64'(o_fifo_level), 64'd3);
      check("t5_txcount", 64'(txq.size()), 64'd1);
      check("t5_hdr", 64'((txq.size() > 0) ? txq.pop_front() : 8'h00), 64'h55);
      check("t5_busy", 64'(o_busy), 64'd1);

      // Reset during T_WAIT clears outputs immediately
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      check_reset_outputs("rst_twait");
      idle(2);
      i_rst = 1'b0;
      txq.delete();
      tx_auto = 1'b1;
      idle(2);

      // Reset during R_A
      send_byte(8'hA0); send_byte(8'h07); idle(1);
      @(negedge i_clk);
      i_rst = 1'b1;
      #1;
      check("rst_ra_busy", 64'(o_busy), 64'd0);
      idle(2);
      i_rst = 1'b0;
      idle(2);

      base_iss = iss_cnt;
      send_a0(8'h05, 8'h00, 8'h00);
      wait_issue(base_iss + 1, 50);
      check("t6_x", 64'(iss_x), 64'h026de);
      check("t6_alpha", 64'(iss_a), 64'h00005);
      expect_frame("t6", 40'h00_9B78_0005);
      idle(40);
      check("t6_nostray", 64'(txq.size()), 64'd0);
      check("dv_before_done", 64'(dv_viol), 64'd0);
      check("done_to_dv_latency", 64'(lat_err), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
